// File: rtl/fp16_pkg.sv
// fp16_pkg: shared 16-bit float format definitions (field positions, constants, divider FSM states)
package fp16_pkg;
  localparam int SIGN   = 15;
  localparam int EXP_HI = 14;
  localparam int EXP_LO = 7;
  localparam int MAN_HI = 6;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  typedef logic [15:0] fp16_t;
  localparam fp16_t FP_ZERO = 16'h0000;
  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} divf_state_t;
endpackage

// File: rtl/divf_mant_step.sv
// divf_mant_step: one restoring-division step; ports r/d in, qbit and shifted next remainder out
module divf_mant_step (
  input  logic [9:0] r,
  input  logic [7:0] d,
  output logic       qbit,
  output logic [9:0] r_nx
);
  always_comb begin
    qbit = r >= {2'b00, d};
    r_nx = (qbit ? r - {2'b00, d} : r) << 1;
  end
endmodule

// File: rtl/divf_seq.sv
// divf_seq: sequential fp16 divider a/b; start/busy/done handshake, result with dz/ovf flags
module divf_seq
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        dz,
  output logic        ovf
);
  divf_state_t       state;
  logic              sign, azero, bzero, qbit;
  logic signed [9:0] e, exp_n;
  logic [9:0]        r, r_nx;
  logic [7:0]        d;
  logic [8:0]        q;
  logic [3:0]        cnt;
  logic [6:0]        man;
  logic              ovf_n;
  fp16_t             res_n;
  divf_mant_step u_step (.r(r), .d(d), .qbit(qbit), .r_nx(r_nx));
  // A quotient below 1.0 shifts up one place, costing one exponent step.
  always_comb begin
    exp_n = q[8] ? e : e - 10'sd1;
    man   = q[8] ? q[7:1] : q[6:0];
    ovf_n = !bzero && !azero && exp_n >= 10'sd255;
    res_n = (bzero || ovf_n) ? {sign, 8'hFF, 7'h00} :
            (azero || exp_n <= 10'sd0) ? FP_ZERO : {sign, exp_n[7:0], man};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= FP_ZERO;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      sign   <= 1'b0;
      azero  <= 1'b0;
      bzero  <= 1'b0;
      e      <= '0;
      r      <= '0;
      d      <= '0;
      q      <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sign  <= a[SIGN] ^ b[SIGN];
          e     <= {2'b00, a[EXP_HI:EXP_LO]} - {2'b00, b[EXP_HI:EXP_LO]} + 10'(FP_BIAS);
          r     <= {3'b001, a[MAN_HI:0]};
          d     <= {1'b1, b[MAN_HI:0]};
          azero <= a == FP_ZERO;
          bzero <= b == FP_ZERO;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= DIV;
        end
        DIV: begin
          q     <= {q[7:0], qbit};
          r     <= r_nx;
          cnt   <= cnt + 4'd1;
          state <= cnt == 4'd8 ? NORM : DIV;
        end
        NORM: begin
          result <= res_n;
          dz     <= bzero;
          ovf    <= ovf_n;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_divf_seq.sv
// tb_divf_seq: scoreboard bench for divf_seq with directed and random operands
module tb_divf_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, dz, ovf;
  logic [15:0] result;
  int checks = 0, failures = 0, cyc = 0;
  typedef struct {logic [15:0] r; logic dz; logic ovf; int acc;} exp_t;
  exp_t sbq[$];
  logic [49:0] dir [8] = '{
    {16'h40C0, 16'h4000, 16'h4040, 1'b0, 1'b0},
    {16'h3F80, 16'h4040, 16'h3EAA, 1'b0, 1'b0},
    {16'hC0C0, 16'h4000, 16'hC040, 1'b0, 1'b0},
    {16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0},
    {16'h3F80, 16'h0000, 16'h7F80, 1'b1, 1'b0},
    {16'hBF80, 16'h0000, 16'hFF80, 1'b1, 1'b0},
    {16'h7F00, 16'h0080, 16'h7F80, 1'b0, 1'b1},
    {16'h0080, 16'h7F00, 16'h0000, 1'b0, 1'b0}};

  divf_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                .busy(busy), .done(done), .result(result), .dz(dz), .ovf(ovf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Quotient from plain integer arithmetic on the value of the operands.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
    logic s;
    int qi, ex, mn;
    s = x[15] ^ y[15];
    if (y == 16'h0000) return {s, 8'hFF, 7'h00, 1'b1, 1'b0};
    if (x == 16'h0000) return 18'h0;
    qi = ((128 + int'(x[6:0])) * 256) / (128 + int'(y[6:0]));
    ex = int'(x[14:7]) - int'(y[14:7]) + 127;
    if (qi >= 256) mn = (qi >> 1) & 127;
    else begin
      mn = qi & 127;
      ex = ex - 1;
    end
    if (ex >= 255) return {s, 8'hFF, 7'h00, 1'b0, 1'b1};
    if (ex <= 0) return 18'h0;
    return {s, 8'(ex), 7'(mn), 2'b00};
  endfunction

  always @(negedge clk) begin
    exp_t ex;
    if (rst_n && done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ex = sbq.pop_front();
        chk("result", 32'(result), 32'(ex.r));
        chk("dz", 32'(dz), 32'(ex.dz));
        chk("ovf", 32'(ovf), 32'(ex.ovf));
        chk("latency", cyc - ex.acc, 10);
        chk("busy_with_done", 32'(busy), 1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [17:0] er);
    exp_t ex;
    wait_idle();
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ex.r = er[17:2];
    ex.dz = er[1];
    ex.ovf = er[0];
    ex.acc = cyc;
    sbq.push_back(ex);
    chk("busy_after_accept", 32'(busy), 1);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("reset_state", {11'b0, busy, done, dz, ovf, result}, 0);
    rst_n = 1'b1;
    foreach (dir[i]) issue(dir[i][49:34], dir[i][33:18], dir[i][17:0]);
    wait_idle();
    // Starts during DIV and during the DONE cycle must both be dropped.
    issue(16'h40C0, 16'h4000, {16'h4040, 2'b00});
    repeat (2) @(negedge clk);
    a = 16'h4000;
    b = 16'h3F80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
    repeat (15) @(negedge clk);
    chk("no_queued_start", 32'(busy), 0);
    // Asynchronous reset mid-operation discards the pending result.
    issue(16'h40C0, 16'h4000, {16'h4040, 2'b00});
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {11'b0, busy, done, dz, ovf, result}, 0);
    sbq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("idle_after_reset", {31'b0, busy}, 0);
    issue(16'h3F80, 16'h4040, {16'h3EAA, 2'b00});
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 9 == 0) rb = 16'h0000;
      if (i % 7 == 0) ra = 16'h0000;
      issue(ra, rb, model(ra, rb));
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("pending", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
